exp7_unidade_controle: RTL and testbench
========================================

EXP7_UNIDADE_CONTROLE -- requirements
Module: exp7_unidade_controle

Interface
REQ-001 Parameters: none; the only build option is the TIMEOUT_EN macro (REQ-030).
REQ-002 clock  in  1  system clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 iniciar  in  1  start request, level-sampled.
REQ-005 jogada_feita, jogada_correta, enderecoIgualRodada  in  1 each  datapath conditions.
REQ-006 meioCR, fimCR, fimTM, meioTM, fimTempo, meioTempo  in  1 each  counter/timer conditions.
REQ-007 nivel_jogadas_reg, nivel_tempo_reg, modo2_reg  in  1 each  registered game configuration.
REQ-008 zeraR, registraR, zeraC, contaC, registraN, zeraCR, contaCR, zeraTM, contaTM, zeraTempo, contaTempo  out  1 each  datapath register/counter controls.
REQ-009 ativa_leds_mem, ativa_leds_jog, toca, gravaM  out  1 each  LED source, buzzer and memory-write controls.
REQ-010 pronto, ganhou, perdeu, timeout  out  1 each  game status.
REQ-011 db_estado  out  4  current state code, debug only.

Function
REQ-012 Moore FSM: registered state; outputs decode state only, so an input seen at edge N changes outputs after edge N.
REQ-013 State codes: inicial=0, preparacao=1, inicio_rodada=2, mostra=3, proximo_mostra=4, inicia_jogadas=5, espera_jogada=6, registra=7, feedback=8, compara=9, proxima_jogada=A, proxima_rodada=B, espera_nova=C, grava_nova=D, fim_acerto=E, fim_erro=F; timeout uses fim_erro with a timeout flag (REQ-027).
REQ-014 inicial: all outputs 0; iniciar=1 -> preparacao.
REQ-015 preparacao: zeraR, zeraC, zeraCR, zeraTM, zeraTempo and registraN high for exactly one cycle -> inicio_rodada.
REQ-016 inicio_rodada: zeraC, zeraTM, zeraTempo high; modo2_reg=0 -> mostra; modo2_reg=1 -> inicia_jogadas (no playback in mode 2).
REQ-017 mostra: ativa_leds_mem, toca, contaTM high; fimTM -> proximo_mostra.
REQ-018 proximo_mostra: zeraTM high; enderecoIgualRodada -> inicia_jogadas, else contaC high this cycle -> mostra.
REQ-019 inicia_jogadas: zeraC, zeraTempo high -> espera_jogada.
REQ-020 espera_jogada: contaTempo high; jogada_feita -> registra; timeout condition (REQ-027) -> fim_erro with timeout set; jogada_feita wins when both occur in the same cycle.
REQ-021 registra: registraR, zeraTM high -> feedback.
REQ-022 feedback: ativa_leds_jog, toca, contaTM high; meioTM -> compara.
REQ-023 compara: !jogada_correta -> fim_erro; correct and !enderecoIgualRodada -> proxima_jogada; correct and enderecoIgualRodada -> fim_acerto if last round (REQ-026), else (modo2_reg ? espera_nova : proxima_rodada).
REQ-024 proxima_jogada: contaC, zeraTempo high -> espera_jogada. proxima_rodada: contaCR high -> inicio_rodada.
REQ-025 espera_nova: contaTempo high; jogada_feita -> grava_nova; grava_nova: contaC then gravaM asserted in separate cycles (contaC cycle first), then contaCR -> inicio_rodada.
REQ-026 Last round = (nivel_jogadas_reg ? fimCR : meioCR).
REQ-027 Timeout condition = (nivel_tempo_reg ? meioTempo : fimTempo).
REQ-028 fim_acerto: ganhou, pronto high; fim_erro: perdeu, pronto high, timeout high iff entered by timeout; from either, iniciar=1 -> preparacao, held otherwise; iniciar ignored in all other states.

Reset
REQ-029 reset=0 forces inicial immediately regardless of clock; all outputs 0, timeout flag cleared, db_estado=0; mid-game reset aborts with no further gravaM/contaC pulse.

Configuration
REQ-030 TIMEOUT_EN defined: REQ-020/REQ-027 apply in espera_jogada and espera_nova. Undefined: contaTempo held 0, timeout inputs ignored, timeout output tied 0, game waits indefinitely.

Verification
REQ-031 reset low mid-mostra -> db_estado=0 and all outputs 0 before the next clock edge.
REQ-032 modo2=0, nivel_jogadas=0, all plays correct -> ganhou=1 after round where meioCR=1; contaCR pulses counted = 7.
REQ-033 Wrong play in round 3 (jogada_correta=0 in compara) -> perdeu=1, timeout=0, db_estado=F.
REQ-034 TIMEOUT_EN, nivel_tempo=1, no play -> meioTempo -> perdeu=1, timeout=1; same cycle with jogada_feita -> db_estado=7 instead.
REQ-035 modo2=1, round completed -> espera_nova, play -> contaC pulse then gravaM pulse, then db_estado=2.
REQ-036 From fim_acerto, iniciar=1 -> preparacao with single-cycle registraN and zeraCR.

Source files
------------

// File: rtl/exp7_unidade_controle.sv
// Moore control unit for the memory game: sequences playback, play capture and end-of-game status.
// Build option: define TIMEOUT_EN to enable the play timeout in espera_jogada and espera_nova.

module exp7_unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       jogada_correta,
  input  logic       enderecoIgualRodada,
  input  logic       meioCR,
  input  logic       fimCR,
  input  logic       fimTM,
  input  logic       meioTM,
  input  logic       fimTempo,
  input  logic       meioTempo,
  input  logic       nivel_jogadas_reg,
  input  logic       nivel_tempo_reg,
  input  logic       modo2_reg,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraC,
  output logic       contaC,
  output logic       registraN,
  output logic       zeraCR,
  output logic       contaCR,
  output logic       zeraTM,
  output logic       contaTM,
  output logic       zeraTempo,
  output logic       contaTempo,
  output logic       ativa_leds_mem,
  output logic       ativa_leds_jog,
  output logic       toca,
  output logic       gravaM,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIO_RODADA  = 4'h2,
    MOSTRA         = 4'h3,
    PROXIMO_MOSTRA = 4'h4,
    INICIA_JOGADAS = 4'h5,
    ESPERA_JOGADA  = 4'h6,
    REGISTRA       = 4'h7,
    FEEDBACK       = 4'h8,
    COMPARA        = 4'h9,
    PROXIMA_JOGADA = 4'hA,
    PROXIMA_RODADA = 4'hB,
    ESPERA_NOVA    = 4'hC,
    GRAVA_NOVA     = 4'hD,
    FIM_ACERTO     = 4'hE,
    FIM_ERRO       = 4'hF
  } estado_t;

  typedef struct packed {
    logic zera_r;
    logic registra_r;
    logic zera_c;
    logic conta_c;
    logic registra_n;
    logic zera_cr;
    logic conta_cr;
    logic zera_tm;
    logic conta_tm;
    logic zera_tempo;
    logic conta_tempo;
    logic leds_mem;
    logic leds_jog;
    logic toca;
    logic grava_m;
    logic pronto;
    logic ganhou;
    logic perdeu;
    logic timeout;
  } saidas_t;

  estado_t     estado_q, estado_d;
  logic [1:0]  fase_q, fase_d;          // sub-step inside grava_nova: contaC, gravaM, contaCR
  logic        timeout_flag_q, timeout_flag_d;
  saidas_t     saidas_q, saidas_d;
  logic        tempo_esgotado_s;
  logic        ultima_rodada_s;
  logic        conta_c_mostra_s;

`ifdef TIMEOUT_EN
  assign tempo_esgotado_s = nivel_tempo_reg ? meioTempo : fimTempo;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^{nivel_tempo_reg, meioTempo, fimTempo};
  assign tempo_esgotado_s = 1'b0;
`endif

  assign ultima_rodada_s = nivel_jogadas_reg ? fimCR : meioCR;

  // Next-state logic, including grava_nova sub-step and timeout flag.
  always_comb begin
    estado_d       = estado_q;
    fase_d         = 2'd0;
    timeout_flag_d = timeout_flag_q;
    case (estado_q)
      INICIAL: begin
        timeout_flag_d = 1'b0;
        if (iniciar) estado_d = PREPARACAO;
        else         estado_d = INICIAL;
      end
      PREPARACAO: begin
        timeout_flag_d = 1'b0;
        estado_d       = INICIO_RODADA;
      end
      INICIO_RODADA: begin
        if (modo2_reg) estado_d = INICIA_JOGADAS;
        else           estado_d = MOSTRA;
      end
      MOSTRA: begin
        if (fimTM) estado_d = PROXIMO_MOSTRA;
        else       estado_d = MOSTRA;
      end
      PROXIMO_MOSTRA: begin
        if (enderecoIgualRodada) estado_d = INICIA_JOGADAS;
        else                     estado_d = MOSTRA;
      end
      INICIA_JOGADAS: estado_d = ESPERA_JOGADA;
      // A play in the same cycle as the timeout takes priority.
      ESPERA_JOGADA: begin
        if (jogada_feita) begin
          estado_d = REGISTRA;
        end else if (tempo_esgotado_s) begin
          estado_d       = FIM_ERRO;
          timeout_flag_d = 1'b1;
        end else begin
          estado_d = ESPERA_JOGADA;
        end
      end
      REGISTRA: estado_d = FEEDBACK;
      FEEDBACK: begin
        if (meioTM) estado_d = COMPARA;
        else        estado_d = FEEDBACK;
      end
      COMPARA: begin
        if (!jogada_correta) begin
          estado_d       = FIM_ERRO;
          timeout_flag_d = 1'b0;
        end else if (!enderecoIgualRodada) begin
          estado_d = PROXIMA_JOGADA;
        end else if (ultima_rodada_s) begin
          estado_d = FIM_ACERTO;
        end else if (modo2_reg) begin
          estado_d = ESPERA_NOVA;
        end else begin
          estado_d = PROXIMA_RODADA;
        end
      end
      PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
      PROXIMA_RODADA: estado_d = INICIO_RODADA;
      ESPERA_NOVA: begin
        if (jogada_feita) begin
          estado_d = GRAVA_NOVA;
        end else if (tempo_esgotado_s) begin
          estado_d       = FIM_ERRO;
          timeout_flag_d = 1'b1;
        end else begin
          estado_d = ESPERA_NOVA;
        end
      end
      GRAVA_NOVA: begin
        if (fase_q == 2'd2) begin
          estado_d = INICIO_RODADA;
          fase_d   = 2'd0;
        end else begin
          estado_d = GRAVA_NOVA;
          fase_d   = fase_q + 2'd1;
        end
      end
      FIM_ACERTO, FIM_ERRO: begin
        if (iniciar) estado_d = PREPARACAO;
        else         estado_d = estado_q;
      end
      default: begin
        estado_d       = INICIAL;
        timeout_flag_d = 1'b0;
      end
    endcase
  end

  // Output decode of the upcoming state, so registered outputs line up with db_estado.
  always_comb begin
    saidas_d = '0;
    case (estado_d)
      INICIAL: saidas_d = '0;
      PREPARACAO: begin
        saidas_d.zera_r     = 1'b1;
        saidas_d.zera_c     = 1'b1;
        saidas_d.zera_cr    = 1'b1;
        saidas_d.zera_tm    = 1'b1;
        saidas_d.zera_tempo = 1'b1;
        saidas_d.registra_n = 1'b1;
      end
      INICIO_RODADA: begin
        saidas_d.zera_c     = 1'b1;
        saidas_d.zera_tm    = 1'b1;
        saidas_d.zera_tempo = 1'b1;
      end
      MOSTRA: begin
        saidas_d.leds_mem = 1'b1;
        saidas_d.toca     = 1'b1;
        saidas_d.conta_tm = 1'b1;
      end
      PROXIMO_MOSTRA: saidas_d.zera_tm = 1'b1;
      INICIA_JOGADAS: begin
        saidas_d.zera_c     = 1'b1;
        saidas_d.zera_tempo = 1'b1;
      end
      ESPERA_JOGADA, ESPERA_NOVA: begin
`ifdef TIMEOUT_EN
        saidas_d.conta_tempo = 1'b1;
`else
        saidas_d.conta_tempo = 1'b0;
`endif
      end
      REGISTRA: begin
        saidas_d.registra_r = 1'b1;
        saidas_d.zera_tm    = 1'b1;
      end
      FEEDBACK: begin
        saidas_d.leds_jog = 1'b1;
        saidas_d.toca     = 1'b1;
        saidas_d.conta_tm = 1'b1;
      end
      COMPARA: saidas_d = '0;
      PROXIMA_JOGADA: begin
        saidas_d.conta_c    = 1'b1;
        saidas_d.zera_tempo = 1'b1;
      end
      PROXIMA_RODADA: saidas_d.conta_cr = 1'b1;
      GRAVA_NOVA: begin
        case (fase_d)
          2'd0:    saidas_d.conta_c  = 1'b1;
          2'd1:    saidas_d.grava_m  = 1'b1;
          2'd2:    saidas_d.conta_cr = 1'b1;
          default: saidas_d.conta_c  = 1'b0;
        endcase
      end
      FIM_ACERTO: begin
        saidas_d.ganhou = 1'b1;
        saidas_d.pronto = 1'b1;
      end
      FIM_ERRO: begin
        saidas_d.perdeu  = 1'b1;
        saidas_d.pronto  = 1'b1;
        saidas_d.timeout = timeout_flag_d;
      end
      default: saidas_d = '0;
    endcase
  end

  // State, sub-step, timeout flag and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q       <= INICIAL;
      fase_q         <= 2'd0;
      timeout_flag_q <= 1'b0;
      saidas_q       <= '0;
    end else begin
      estado_q       <= estado_d;
      fase_q         <= fase_d;
      timeout_flag_q <= timeout_flag_d;
      saidas_q       <= saidas_d;
    end
  end

  // Playback advance depends on the address compare made within proximo_mostra itself.
  assign conta_c_mostra_s = (estado_q == PROXIMO_MOSTRA) && !enderecoIgualRodada;

  assign zeraR          = saidas_q.zera_r;
  assign registraR      = saidas_q.registra_r;
  assign zeraC          = saidas_q.zera_c;
  assign contaC         = saidas_q.conta_c | conta_c_mostra_s;
  assign registraN      = saidas_q.registra_n;
  assign zeraCR         = saidas_q.zera_cr;
  assign contaCR        = saidas_q.conta_cr;
  assign zeraTM         = saidas_q.zera_tm;
  assign contaTM        = saidas_q.conta_tm;
  assign zeraTempo      = saidas_q.zera_tempo;
  assign contaTempo     = saidas_q.conta_tempo;
  assign ativa_leds_mem = saidas_q.leds_mem;
  assign ativa_leds_jog = saidas_q.leds_jog;
  assign toca           = saidas_q.toca;
  assign gravaM         = saidas_q.grava_m;
  assign pronto         = saidas_q.pronto;
  assign ganhou         = saidas_q.ganhou;
  assign perdeu         = saidas_q.perdeu;
  assign timeout        = saidas_q.timeout;
  assign db_estado      = estado_q;

endmodule

// File: tb/tb_exp7_unidade_controle.sv
// Bench for exp7_unidade_controle: behavioural datapath around the FSM, game-level expectations.
module tb_exp7_unidade_controle;

  logic clock, reset, iniciar, jogada_feita, jogada_correta, enderecoIgualRodada;
  logic meioCR, fimCR, fimTM, meioTM, fimTempo, meioTempo;
  logic nivel_jogadas_reg, nivel_tempo_reg, modo2_reg;
  logic zeraR, registraR, zeraC, contaC, registraN, zeraCR, contaCR, zeraTM, contaTM;
  logic zeraTempo, contaTempo, ativa_leds_mem, ativa_leds_jog, toca, gravaM;
  logic pronto, ganhou, perdeu, timeout;
  logic [3:0] db_estado;

  int n_vec = 0;
  int n_err = 0;

  // datapath model state
  int c, cr, tm, tempo;
  int wrong_r = -1;
  int wrong_i = -1;

  // event counters (never cleared; tests take differences)
  int n_conta_cr, n_registra_r, n_grava_m, n_leds_mem, n_registra_n, n_zera_cr;
  int n_conta_c, n_conta_tempo, n_order_err, n_bad_gap;
  int gap;
  bit pending, prev_cc;

  wire [19:0] all_outs = {zeraR, registraR, zeraC, contaC, registraN, zeraCR, contaCR, zeraTM,
                          contaTM, zeraTempo, contaTempo, ativa_leds_mem, ativa_leds_jog, toca,
                          gravaM, pronto, ganhou, perdeu, timeout};

  exp7_unidade_controle dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .jogada_correta(jogada_correta), .enderecoIgualRodada(enderecoIgualRodada),
    .meioCR(meioCR), .fimCR(fimCR), .fimTM(fimTM), .meioTM(meioTM),
    .fimTempo(fimTempo), .meioTempo(meioTempo), .nivel_jogadas_reg(nivel_jogadas_reg),
    .nivel_tempo_reg(nivel_tempo_reg), .modo2_reg(modo2_reg),
    .zeraR(zeraR), .registraR(registraR), .zeraC(zeraC), .contaC(contaC),
    .registraN(registraN), .zeraCR(zeraCR), .contaCR(contaCR), .zeraTM(zeraTM),
    .contaTM(contaTM), .zeraTempo(zeraTempo), .contaTempo(contaTempo),
    .ativa_leds_mem(ativa_leds_mem), .ativa_leds_jog(ativa_leds_jog), .toca(toca),
    .gravaM(gravaM), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
    .timeout(timeout), .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign enderecoIgualRodada = (c == cr);
  assign meioCR     = (cr == 7);
  assign fimCR      = (cr == 15);
  assign fimTM      = (tm >= 3);
  assign meioTM     = (tm >= 1);
  assign meioTempo  = (tempo >= 10);
  assign fimTempo   = (tempo >= 20);
  assign jogada_correta = !((cr == wrong_r) && (c == wrong_i));

  // datapath counters driven by the FSM controls
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      c <= 0; cr <= 0; tm <= 0; tempo <= 0; pending <= 1'b0; prev_cc <= 1'b0; gap <= 0;
    end else begin
      if (zeraC) c <= 0; else if (contaC) c <= c + 1;
      if (zeraCR) cr <= 0; else if (contaCR) cr <= cr + 1;
      if (zeraTM) tm <= 0; else if (contaTM) tm <= tm + 1;
      if (zeraTempo) tempo <= 0; else if (contaTempo) tempo <= tempo + 1;
      prev_cc <= contaC && !gravaM;
      if (gravaM) begin
        pending <= 1'b1;
        gap <= 0;
        n_order_err <= n_order_err + ((prev_cc) ? 0 : 1) + ((c == cr + 1) ? 0 : 1);
      end else if (pending) begin
        if (db_estado == 4'h2) begin
          pending <= 1'b0;
          if (gap + 1 != 2) n_bad_gap <= n_bad_gap + 1;
        end else if (gap > 5) begin
          pending <= 1'b0;
          n_bad_gap <= n_bad_gap + 1;
        end else begin
          gap <= gap + 1;
        end
      end
    end
  end

  // raw pulse counting, also active while reset is held
  always @(posedge clock) begin
    if (contaCR)        n_conta_cr    <= n_conta_cr + 1;
    if (registraR)      n_registra_r  <= n_registra_r + 1;
    if (gravaM)         n_grava_m     <= n_grava_m + 1;
    if (ativa_leds_mem) n_leds_mem    <= n_leds_mem + 1;
    if (registraN)      n_registra_n  <= n_registra_n + 1;
    if (zeraCR)         n_zera_cr     <= n_zera_cr + 1;
    if (contaC)         n_conta_c     <= n_conta_c + 1;
    if (contaTempo)     n_conta_tempo <= n_conta_tempo + 1;
  end

  task automatic hard_reset();
    reset = 1'b0; iniciar = 1'b0; jogada_feita = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic start_game(input bit m2, input bit nj, input bit nt);
    modo2_reg = m2; nivel_jogadas_reg = nj; nivel_tempo_reg = nt;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  task automatic play_game(input int budget, input bit noise, output bit done);
    int wait_cnt;
    wait_cnt = $urandom_range(0, 3);
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      if (pronto) begin
        done = 1'b1;
      end else begin
        if (db_estado == 4'h6 || db_estado == 4'hC) begin
          if (wait_cnt == 0) begin jogada_feita = 1'b1; wait_cnt = $urandom_range(0, 3); end
          else begin jogada_feita = 1'b0; wait_cnt--; end
        end else begin
          jogada_feita = 1'b0;
        end
        iniciar = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clock);
      end
    end
    jogada_feita = 1'b0; iniciar = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; iniciar = 1'b0; jogada_feita = 1'b0;
    modo2_reg = 1'b0; nivel_jogadas_reg = 1'b0; nivel_tempo_reg = 1'b0;
    #12;
    n_vec++; if (db_estado !== 4'h0) begin n_err++; $display("FAIL reset_state: got %h expected 0", db_estado); end
    n_vec++; if (all_outs !== 20'h0) begin n_err++; $display("FAIL reset_outs: got %h expected 0", all_outs); end
    @(negedge clock); reset = 1'b1;
    repeat (3) @(negedge clock);
    n_vec++; if (db_estado !== 4'h0) begin n_err++; $display("FAIL idle_hold: got %h expected 0", db_estado); end
  endtask

  // Full game with expectations from the rules: round r replays r+1 items (4 cycles each) and needs r+1 plays.
  task automatic test_game(input string name, input bit m2, input bit nj, input int wr, input int wi, input bit noise);
    int rounds, e_cr, e_reg, e_leds, e_grava;
    int s_cr, s_reg, s_leds, s_grava, s_order, s_gap;
    bit done, win;
    rounds = nj ? 16 : 8;
    win = (wr < 0);
    if (win) begin
      e_cr = rounds - 1; e_reg = rounds * (rounds + 1) / 2;
      e_leds = m2 ? 0 : 4 * e_reg; e_grava = m2 ? rounds - 1 : 0;
    end else begin
      e_cr = wr; e_reg = wr * (wr + 1) / 2 + wi + 1;
      e_leds = m2 ? 0 : 2 * (wr + 1) * (wr + 2); e_grava = m2 ? wr : 0;
    end
    hard_reset();
    wrong_r = wr; wrong_i = wi;
    s_cr = n_conta_cr; s_reg = n_registra_r; s_leds = n_leds_mem; s_grava = n_grava_m;
    s_order = n_order_err; s_gap = n_bad_gap;
    start_game(m2, nj, 1'b0);
    play_game(8000, noise, done);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL %s finish: got %0d expected 1 (cycle budget)", name, done); end
    n_vec++; if (ganhou !== win) begin n_err++; $display("FAIL %s ganhou: got %0d expected %0d", name, ganhou, win); end
    n_vec++; if (perdeu !== !win) begin n_err++; $display("FAIL %s perdeu: got %0d expected %0d", name, perdeu, !win); end
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL %s timeout: got %0d expected 0", name, timeout); end
    n_vec++; if (db_estado !== (win ? 4'hE : 4'hF)) begin n_err++; $display("FAIL %s db_estado: got %h expected %h", name, db_estado, win ? 4'hE : 4'hF); end
    n_vec++; if (n_conta_cr - s_cr != e_cr) begin n_err++; $display("FAIL %s contaCR_pulses: got %0d expected %0d", name, n_conta_cr - s_cr, e_cr); end
    n_vec++; if (n_registra_r - s_reg != e_reg) begin n_err++; $display("FAIL %s plays: got %0d expected %0d", name, n_registra_r - s_reg, e_reg); end
    n_vec++; if (n_leds_mem - s_leds != e_leds) begin n_err++; $display("FAIL %s playback_cycles: got %0d expected %0d", name, n_leds_mem - s_leds, e_leds); end
    n_vec++; if (n_grava_m - s_grava != e_grava) begin n_err++; $display("FAIL %s gravaM_pulses: got %0d expected %0d", name, n_grava_m - s_grava, e_grava); end
    n_vec++; if (n_order_err - s_order != 0 || n_bad_gap - s_gap != 0) begin n_err++; $display("FAIL %s grava_order: got %0d/%0d expected 0/0", name, n_order_err - s_order, n_bad_gap - s_gap); end
    wrong_r = -1; wrong_i = -1;
  endtask

  task automatic test_restart();
    int s_n, s_z;
    n_vec++; if (db_estado !== 4'hE) begin n_err++; $display("FAIL restart_pre: got %h expected e", db_estado); end
    s_n = n_registra_n; s_z = n_zera_cr;
    iniciar = 1'b1; @(negedge clock); iniciar = 1'b0;
    n_vec++; if (db_estado !== 4'h1) begin n_err++; $display("FAIL restart_state: got %h expected 1", db_estado); end
    repeat (4) @(negedge clock);
    n_vec++; if (n_registra_n - s_n != 1) begin n_err++; $display("FAIL restart_registraN: got %0d expected 1", n_registra_n - s_n); end
    n_vec++; if (n_zera_cr - s_z != 1) begin n_err++; $display("FAIL restart_zeraCR: got %0d expected 1", n_zera_cr - s_z); end
    n_vec++; if (pronto !== 1'b0) begin n_err++; $display("FAIL restart_pronto: got %0d expected 0", pronto); end
  endtask

  task automatic test_mode2_sequence();
    logic [6:0] exp_tr [4];
    bit found;
    exp_tr[0] = {4'hD, 3'b100}; exp_tr[1] = {4'hD, 3'b010};
    exp_tr[2] = {4'hD, 3'b001}; exp_tr[3] = {4'h2, 3'b000};
    hard_reset();
    start_game(1'b1, 1'b0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (db_estado == 4'hC) found = 1'b1;
      else begin jogada_feita = (db_estado == 4'h6); @(negedge clock); end
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL m2_reach_espera_nova: got 0 expected 1"); end
    jogada_feita = 1'b1; @(negedge clock); jogada_feita = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({db_estado, contaC, gravaM, contaCR} !== exp_tr[k]) begin
        n_err++; $display("FAIL m2_trace[%0d]: got %h expected %h", k, {db_estado, contaC, gravaM, contaCR}, exp_tr[k]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid_game();
    bit found;
    int s_c, s_g;
    hard_reset();
    start_game(1'b0, 1'b0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (ativa_leds_mem) found = 1'b1; else @(negedge clock);
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL mid_reach_mostra: got 0 expected 1"); end
    #2 reset = 1'b0;
    #1;
    n_vec++; if (db_estado !== 4'h0) begin n_err++; $display("FAIL mid_reset_state: got %h expected 0", db_estado); end
    n_vec++; if (all_outs !== 20'h0) begin n_err++; $display("FAIL mid_reset_outs: got %h expected 0", all_outs); end
    @(negedge clock); reset = 1'b1;
    start_game(1'b1, 1'b0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (db_estado == 4'hD) found = 1'b1;
      else begin jogada_feita = (db_estado == 4'h6 || db_estado == 4'hC); @(negedge clock); end
    end
    jogada_feita = 1'b0;
    n_vec++; if (!found) begin n_err++; $display("FAIL mid_reach_grava: got 0 expected 1"); end
    #2 reset = 1'b0;
    #1;
    s_c = n_conta_c; s_g = n_grava_m;
    n_vec++; if ({contaC, gravaM} !== 2'b00) begin n_err++; $display("FAIL grava_abort_outs: got %b expected 00", {contaC, gravaM}); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_vec++; if (n_conta_c - s_c != 0 || n_grava_m - s_g != 0) begin n_err++; $display("FAIL grava_abort_pulses: got %0d/%0d expected 0/0", n_conta_c - s_c, n_grava_m - s_g); end
    n_vec++; if (db_estado !== 4'h0) begin n_err++; $display("FAIL grava_abort_state: got %h expected 0", db_estado); end
  endtask

`ifdef TIMEOUT_EN
  task automatic test_timeout();
    bit done, hit;
    int s_t;
    for (int lvl = 1; lvl >= 0; lvl--) begin
      hard_reset();
      s_t = n_conta_tempo;
      start_game(1'b0, 1'b0, 1'(lvl));
      done = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
        if (pronto) done = 1'b1; else @(negedge clock);
      end
      n_vec++; if (!done) begin n_err++; $display("FAIL timeout_finish_lvl%0d: got 0 expected 1", lvl); end
      n_vec++; if ({perdeu, timeout, ganhou} !== 3'b110) begin n_err++; $display("FAIL timeout_flags_lvl%0d: got %b expected 110", lvl, {perdeu, timeout, ganhou}); end
      n_vec++; if (db_estado !== 4'hF) begin n_err++; $display("FAIL timeout_state_lvl%0d: got %h expected f", lvl, db_estado); end
      n_vec++; if (n_conta_tempo - s_t != (lvl ? 11 : 21)) begin n_err++; $display("FAIL timeout_wait_lvl%0d: got %0d expected %0d", lvl, n_conta_tempo - s_t, lvl ? 11 : 21); end
    end
    hard_reset();
    start_game(1'b0, 1'b0, 1'b1);
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      if (db_estado == 4'h6 && tempo == 10) begin hit = 1'b1; jogada_feita = 1'b1; end
      @(negedge clock);
    end
    jogada_feita = 1'b0;
    n_vec++; if (!hit) begin n_err++; $display("FAIL race_reach: got 0 expected 1"); end
    n_vec++; if ({db_estado, timeout, perdeu} !== 6'h1C) begin n_err++; $display("FAIL race_play_wins: got %h expected 1c", {db_estado, timeout, perdeu}); end
  endtask
`else
  task automatic test_timeout();
    bit found;
    int s_t;
    hard_reset();
    s_t = n_conta_tempo;
    start_game(1'b0, 1'b0, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (db_estado == 4'h6) found = 1'b1; else @(negedge clock);
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL notimeout_reach: got 0 expected 1"); end
    repeat (60) @(negedge clock);
    n_vec++; if (db_estado !== 4'h6) begin n_err++; $display("FAIL notimeout_wait: got %h expected 6", db_estado); end
    n_vec++; if ({pronto, timeout, perdeu} !== 3'b000) begin n_err++; $display("FAIL notimeout_flags: got %b expected 000", {pronto, timeout, perdeu}); end
    n_vec++; if (n_conta_tempo - s_t != 0) begin n_err++; $display("FAIL notimeout_contaTempo: got %0d expected 0", n_conta_tempo - s_t); end
  endtask
`endif

  task automatic test_random_games();
    bit m2, nj;
    int rounds, wr, wi;
    for (int g = 0; g < 5; g++) begin
      m2 = 1'($urandom_range(0, 1));
      nj = 1'($urandom_range(0, 1));
      rounds = nj ? 16 : 8;
      if ($urandom_range(0, 1) == 0) begin wr = -1; wi = -1; end
      else begin wr = $urandom_range(0, rounds - 1); wi = $urandom_range(0, wr); end
      test_game("random", m2, nj, wr, wi, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_game("win_mode1", 1'b0, 1'b0, -1, -1, 1'b1);
    test_restart();
    test_game("wrong_round3", 1'b0, 1'b0, 2, $urandom_range(0, 2), 1'b0);
    test_game("win_mode2", 1'b1, 1'b0, -1, -1, 1'b0);
    test_mode2_sequence();
    test_reset_mid_game();
    test_timeout();
    test_random_games();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
